i2c_responder: RTL

//  I2C target (responder) for the configuration bus driven by the team's I2C

---
 rtl/i2c_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_responder.sv
// I2C target for the config bus: address match, pointer write, burst write and
// burst read against an external register file through a strobe/address port.
module i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_ACK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_scl_s1, r_scl_s2, r_scl_h;
  logic        r_sda_s1, r_sda_s2, r_sda_h;
  logic [2:0]  r_cnt;
  logic        r_ackph;
  logic        r_rw;
  logic [6:0]  r_rx;
  logic [6:0]  r_tx;
  logic        r_sda_oe, r_busy, r_reg_wr;
  logic [7:0]  r_reg_addr, r_reg_wdata;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_last;
  logic        w_rx_en, w_cnt_en;
  logic [7:0]  w_byte;
  logic        w_oe_nxt, w_busy_nxt, w_wr_nxt, w_ptr_ld;
  logic        w_tx_ld, w_tx_sh, w_rd_inc, w_ack_set;

  // Sync flops reset high so a released bus shows no spurious edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_h} <= {scl_in, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_h} <= {sda_in, r_sda_s1, r_sda_s2};
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_byte     = {r_rx, r_sda_s2};
  assign w_last     = (r_cnt == 3'd7);
  assign w_rx_en    = w_scl_rise &&
                      (r_state == S_ADDR || r_state == S_PTR || r_state == S_WDATA);
  assign w_cnt_en   = w_rx_en || (r_state == S_RDATA && w_scl_fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)       w_state_nxt = S_IDLE;
    else if (w_start) w_state_nxt = S_ADDR;
    else begin
      case (r_state)
        S_ADDR:
          if (w_scl_rise && w_last)
            w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:
          if (w_scl_fall && r_ackph) w_state_nxt = r_rw ? S_RDATA : S_PTR;
        S_PTR:
          if (w_scl_rise && w_last) w_state_nxt = S_PTR_ACK;
        S_PTR_ACK, S_WDATA_ACK:
          if (w_scl_fall && r_ackph) w_state_nxt = S_WDATA;
        S_WDATA:
          if (w_scl_rise && w_last) w_state_nxt = S_WDATA_ACK;
        S_RDATA:
          if (w_scl_fall && w_last) w_state_nxt = S_RD_ACK;
        S_RD_ACK:
          if (w_scl_rise && !r_ackph && r_sda_s2) w_state_nxt = S_IDLE;
          else if (w_scl_fall && r_ackph)         w_state_nxt = S_RDATA;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ACK phase: first fall drives low, second fall releases (or starts a read byte)
  always_comb begin
    w_oe_nxt   = r_sda_oe;
    w_busy_nxt = r_busy;
    w_wr_nxt   = 1'b0;
    w_ptr_ld   = 1'b0;
    w_tx_ld    = 1'b0;
    w_tx_sh    = 1'b0;
    w_rd_inc   = 1'b0;
    w_ack_set  = 1'b0;
    if (w_stop) begin
      w_oe_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
    end else if (w_start) begin
      w_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR:
          if (w_scl_rise && w_last) w_busy_nxt = (w_byte[7:1] == DEV_ADDR);
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK:
          if (w_scl_fall) begin
            if (!r_ackph) begin
              w_oe_nxt  = 1'b1;
              w_ack_set = 1'b1;
            end else if (r_state == S_ADDR_ACK && r_rw) begin
              w_tx_ld  = 1'b1;
              w_oe_nxt = ~reg_rdata[7];
            end else begin
              w_oe_nxt = 1'b0;
            end
          end
        S_PTR:   w_ptr_ld = w_scl_rise && w_last;
        S_WDATA: w_wr_nxt = w_scl_rise && w_last;
        S_RDATA:
          if (w_scl_fall) begin
            if (w_last) w_oe_nxt = 1'b0;
            else begin
              w_tx_sh  = 1'b1;
              w_oe_nxt = ~r_tx[6];
            end
          end
        S_RD_ACK:
          if (w_scl_rise && !r_ackph) begin
            if (r_sda_s2) w_busy_nxt = 1'b0;
            else begin
              w_rd_inc  = 1'b1;
              w_ack_set = 1'b1;
            end
          end else if (w_scl_fall && r_ackph) begin
            w_tx_ld  = 1'b1;
            w_oe_nxt = ~reg_rdata[7];
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_ackph     <= 1'b0;
      r_rw        <= 1'b0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_sda_oe <= w_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_reg_wr <= w_wr_nxt;
      if (w_wr_nxt) r_reg_wdata <= w_byte;
      if (w_ptr_ld)                    r_reg_addr <= w_byte;
      else if (r_reg_wr || w_rd_inc)   r_reg_addr <= r_reg_addr + 8'd1;
      if (w_rx_en) r_rx <= w_byte[6:0];
      if (r_state == S_ADDR && w_rx_en && w_last) r_rw <= r_sda_s2;
      // tx holds bits 6..0; bit 7 goes straight from reg_rdata to the pin
      if (w_tx_ld)      r_tx <= reg_rdata[6:0];
      else if (w_tx_sh) r_tx <= {r_tx[5:0], 1'b0};
      if (w_state_nxt != r_state || w_start) begin
        r_cnt   <= '0;
        r_ackph <= 1'b0;
      end else begin
        if (w_cnt_en)  r_cnt   <= r_cnt + 3'd1;
        if (w_ack_set) r_ackph <= 1'b1;
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign reg_wr    = r_reg_wr;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;

endmodule
